// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM states,
// the default frame start byte and the frame-length field width.
package inst_loader_pkg;

  localparam int unsigned LEN_W         = 16;
  localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_e;

endpackage

// File: rtl/inst_loader_wordpack.sv
// Byte-lane counter and shift register that assembles little-endian
// 32-bit words; word_valid_c/word_c include the byte arriving this cycle.
module inst_loader_wordpack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid_c,
  output logic [31:0] word_c
);

  logic [1:0]  lane_q;
  logic [23:0] shreg_q;

  // Lower three bytes accumulate here; byte 0 ends up in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= 2'd0;
      shreg_q <= 24'd0;
    end else if (clear) begin
      lane_q  <= 2'd0;
    end else if (byte_valid) begin
      lane_q  <= lane_q + 2'd1;
      shreg_q <= {byte_data, shreg_q[23:8]};
    end
  end

  assign word_valid_c = byte_valid && (lane_q == 2'd3);
  assign word_c       = {byte_data, shreg_q};

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction loader: framed UART bytes -> ROM write port, core held
// in reset until a full image lands. Optional checksum byte: INST_LOADER_CSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  MAGIC       = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [63:0] DEPTH = 64'(1) << ADDR_W;
`ifdef INST_LOADER_CSUM_EN
  localparam state_e END_ST = CSUM;
`else
  localparam state_e END_ST = DONE;
`endif

  state_e             state_q, state_d;
  logic [7:0]         cnt_lo_q, cnt_lo_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   widx_q, widx_d;
  logic [TMO_W-1:0]   idle_q, idle_d;
  logic [LEN_W-1:0]   n_c;
  logic               in_frame_c;
  logic               magic_c;
  logic               word_valid_c;
  logic [31:0]        word_c;
  logic               rom_we_d;
  logic [ADDR_W-1:0]  rom_waddr_d;
  logic [31:0]        rom_wdata_d;
`ifdef INST_LOADER_CSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  inst_loader_wordpack u_wordpack (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (state_q != DATA),
    .byte_valid   (rx_valid && (state_q == DATA)),
    .byte_data    (rx_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_lo_q   <= 8'd0;
      cnt_q      <= '0;
      widx_q     <= '0;
      idle_q     <= '0;
      rom_we     <= 1'b0;
      rom_waddr  <= '0;
      rom_wdata  <= 32'd0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef INST_LOADER_CSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      idle_q     <= idle_d;
      rom_we     <= rom_we_d;
      rom_waddr  <= rom_waddr_d;
      rom_wdata  <= rom_wdata_d;
      core_rst_n <= (state_d == DONE);
      done       <= (state_d == DONE);
      err        <= (state_d == ERR);
`ifdef INST_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state, counters and write-port decode.
  always_comb begin
    state_d     = state_q;
    cnt_lo_d    = cnt_lo_q;
    cnt_d       = cnt_q;
    widx_d      = widx_q;
    idle_d      = '0;
    rom_we_d    = 1'b0;
    rom_waddr_d = rom_waddr;
    rom_wdata_d = rom_wdata;
    n_c         = {rx_data, cnt_lo_q};
    in_frame_c  = state_q inside {CNT_LO, CNT_HI, DATA, CSUM};
    magic_c     = rx_valid && (rx_data == MAGIC);
`ifdef INST_LOADER_CSUM_EN
    csum_d      = csum_q;
`endif

    if (in_frame_c && !rx_valid) begin
      idle_d = idle_q + TMO_W'(1);
    end

    case (state_q)
      IDLE, DONE, ERR: begin
        if (magic_c) begin
          state_d = CNT_LO;
`ifdef INST_LOADER_CSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      CNT_LO: begin
        if (rx_valid) begin
          cnt_lo_d = rx_data;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (rx_valid) begin
          cnt_d  = n_c;
          widx_d = '0;
          if (n_c == '0) begin
            state_d = END_ST;
          end else if (64'(n_c) > DEPTH) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
`ifdef INST_LOADER_CSUM_EN
        if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
        end
`endif
        if (word_valid_c) begin
          rom_we_d    = 1'b1;
          rom_waddr_d = ADDR_W'(widx_q);
          rom_wdata_d = word_c;
          widx_d      = widx_q + LEN_W'(1);
          if (widx_q == cnt_q - LEN_W'(1)) begin
            state_d = END_ST;
          end
        end
      end
`ifdef INST_LOADER_CSUM_EN
      CSUM: begin
        if (rx_valid) begin
          state_d = (rx_data == csum_q) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A byte on the expiry cycle keeps the frame alive.
    if (in_frame_c && !rx_valid && (idle_q == TMO_W'(TIMEOUT_CYC - 1))) begin
      state_d = ERR;
    end

    if (!(state_d inside {CNT_LO, CNT_HI, DATA, CSUM})) begin
      idle_d = '0;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader; adapts frames to INST_LOADER_CSUM_EN.
module tb_inst_loader;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned TMO    = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              core_rst_n;
  logic              done;
  logic              err;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] frame_words[$];
  logic [7:0]  run_cs;
  int          tests = 0;
  int          fails = 0;
  int          we_cnt = 0;
  int          we_base;

  inst_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO), .MAGIC(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rom_we     (rom_we),
    .rom_waddr  (rom_waddr),
    .rom_wdata  (rom_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every ROM write must match the oldest expected write.
  always @(negedge clk) begin
    if (rom_we) begin
      we_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rom_write unexpected: addr=%0h data=%h", rom_waddr, rom_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rom_waddr !== mon_e.addr || rom_wdata !== mon_e.data) begin
          fails++;
          $display("FAIL rom_write: got addr=%0h data=%h, want addr=%0h data=%h",
                   rom_waddr, rom_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input int unsigned idx, input logic [31:0] w);
    exp_q.push_back({ADDR_W'(idx), w});
    for (int b = 0; b < 4; b++) begin
      send_byte(w[8*b +: 8]);
      run_cs = run_cs ^ w[8*b +: 8];
    end
  endtask

  task automatic send_frame(input logic corrupt, input logic with_magic);
    logic [15:0] n;
    n      = 16'(frame_words.size());
    run_cs = 8'd0;
    if (with_magic) send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (frame_words[i]) send_word(i, frame_words[i]);
`ifdef INST_LOADER_CSUM_EN
    send_byte(corrupt ? (run_cs ^ 8'h01) : run_cs);
`else
    if (corrupt) $display("[TB] note: build has no checksum byte");
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({rom_we, rom_waddr, rom_wdata, core_rst_n, done, err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got we=%b addr=%0h data=%h core_rst_n=%b done=%b err=%b, want all 0",
               rom_we, rom_waddr, rom_wdata, core_rst_n, done, err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_noise_and_empty();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    @(negedge clk);
    tests++;
    if ({done, err, core_rst_n} !== 3'b000 || we_cnt !== 0) begin
      fails++;
      $display("FAIL idle_noise: got done=%b err=%b core_rst_n=%b writes=%0d, want 0 0 0 0",
               done, err, core_rst_n, we_cnt);
    end
    frame_words.delete();
    send_frame(1'b0, 1'b1);
    tests++;
    if ({done, err, core_rst_n} !== 3'b101 || we_cnt !== 0) begin
      fails++;
      $display("FAIL empty_image: got done=%b err=%b core_rst_n=%b writes=%0d, want 1 0 1 0",
               done, err, core_rst_n, we_cnt);
    end
  endtask

  task automatic test_good_load();
    we_base = we_cnt;
    frame_words = '{32'h0000_0013, 32'h0010_0093};
    send_frame(1'b0, 1'b1);
    @(negedge clk);
    tests++;
    if ({done, err, core_rst_n} !== 3'b101 || (we_cnt - we_base) !== 2) begin
      fails++;
      $display("FAIL good_load: got done=%b err=%b core_rst_n=%b writes=%0d, want 1 0 1 2",
               done, err, core_rst_n, we_cnt - we_base);
    end
  endtask

`ifdef INST_LOADER_CSUM_EN
  task automatic test_bad_csum();
    we_base = we_cnt;
    frame_words = '{32'h0000_0013, 32'h0010_0093};
    send_frame(1'b1, 1'b1);
    @(negedge clk);
    tests++;
    if ({done, err, core_rst_n} !== 3'b010 || (we_cnt - we_base) !== 2) begin
      fails++;
      $display("FAIL bad_csum: got done=%b err=%b core_rst_n=%b writes=%0d, want 0 1 0 2",
               done, err, core_rst_n, we_cnt - we_base);
    end
  endtask
`endif

  task automatic test_oversize();
    we_base = we_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    tests++;
    if ({done, err, core_rst_n} !== 3'b010 || we_cnt !== we_base) begin
      fails++;
      $display("FAIL oversize_4097: got done=%b err=%b core_rst_n=%b writes=%0d, want 0 1 0 0",
               done, err, core_rst_n, we_cnt - we_base);
    end
    // Exactly full depth is legal; abandon it via timeout.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL size_4096_accepted: got err=%b, want 0", err);
    end
    repeat (TMO) @(negedge clk);
    tests++;
    if (err !== 1'b1 || we_cnt !== we_base) begin
      fails++;
      $display("FAIL size_4096_abandoned: got err=%b writes=%0d, want 1 0", err, we_cnt - we_base);
    end
  endtask

  task automatic test_timeout();
    we_base = we_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h13);
    repeat (TMO - 1) @(negedge clk);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: got err=%b after %0d idle cycles, want 0", err, TMO - 1);
    end
    @(negedge clk);
    tests++;
    if (err !== 1'b1 || core_rst_n !== 1'b0 || we_cnt !== we_base) begin
      fails++;
      $display("FAIL timeout_expire: got err=%b core_rst_n=%b writes=%0d, want 1 0 0",
               err, core_rst_n, we_cnt - we_base);
    end
  endtask

  task automatic test_reload();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    tests++;
    if (err !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL err_noise_ignored: got err=%b done=%b, want 1 0", err, done);
    end
    frame_words = '{32'hDEAD_BEEF};
    send_frame(1'b0, 1'b1);
    tests++;
    if (done !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL reload_from_err: got done=%b err=%b, want 1 0", done, err);
    end
    send_byte(8'hA5);
    tests++;
    if (core_rst_n !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reload_rehold: got core_rst_n=%b done=%b, want 0 0", core_rst_n, done);
    end
    frame_words = '{32'h1234_5678};
    send_frame(1'b0, 1'b0);
    tests++;
    if (done !== 1'b1 || core_rst_n !== 1'b1) begin
      fails++;
      $display("FAIL reload_done: got done=%b core_rst_n=%b, want 1 1", done, core_rst_n);
    end
  endtask

  task automatic test_async_reset();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    send_word(0, 32'hCAFE_0001);
    send_word(1, 32'hCAFE_0002);
    send_byte(8'h77); send_byte(8'h66);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({rom_we, rom_waddr, rom_wdata, core_rst_n, done, err} !== '0) begin
      fails++;
      $display("FAIL async_reset: got we=%b addr=%0h data=%h core_rst_n=%b done=%b err=%b, want all 0",
               rom_we, rom_waddr, rom_wdata, core_rst_n, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    frame_words = '{32'h0000_0013, 32'h0010_0093};
    send_frame(1'b0, 1'b1);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || core_rst_n !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_load: got done=%b err=%b core_rst_n=%b, want 1 0 1",
               done, err, core_rst_n);
    end
  endtask

  initial begin
    test_reset();
    test_noise_and_empty();
    test_good_load();
`ifdef INST_LOADER_CSUM_EN
    test_bad_csum();
`endif
    test_oversize();
    test_timeout();
    test_reload();
    test_async_reset();
    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending writes, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
